// File: rtl/serial_sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
// FSM state encoding and default operand width.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  localparam int SS_WIDTH = 8;

endpackage

// File: rtl/fs_bit_cell.sv
// One-bit full subtractor: d = x - y - bin, with borrow out.
// Purely combinational; the caller registers the borrow.
module fs_bit_cell (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic w_xy;

  assign w_xy = x ^ y;
  assign d    = w_xy ^ bin;
  assign bout = (~x & y) | (~w_xy & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one bit per clock with a registered borrow.
// Optional two's-complement overflow output under SERIAL_SUB_OVERFLOW_EN.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = SS_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SERIAL_SUB_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;
  logic             r_bout;
  logic [CNT_W-1:0] r_cnt;
  logic             w_d;
  logic             w_bo;
  logic             w_load;
  logic [WIDTH-1:0] w_res_next;

  fs_bit_cell u_cell (
    .x    (r_a[0]),
    .y    (r_b[0]),
    .bin  (r_borrow),
    .d    (w_d),
    .bout (w_bo)
  );

  assign w_load     = start & (r_state != ST_RUN);
  assign w_res_next = {w_d, r_res[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
      r_bout   <= 1'b0;
      r_cnt    <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_load) begin
            r_a      <= a;
            r_b      <= b;
            r_res    <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            r_state  <= ST_RUN;
          end else begin
            r_state  <= ST_IDLE;
          end
        end
        ST_RUN: begin
          r_a      <= r_a >> 1;
          r_b      <= r_b >> 1;
          r_res    <= w_res_next;
          r_borrow <= w_bo;
          r_cnt    <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_diff  <= w_res_next;
            r_bout  <= w_bo;
            r_state <= ST_DONE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef SERIAL_SUB_OVERFLOW_EN
  logic r_am;
  logic r_bm;
  logic r_ovf;

  // The final cell output is the result MSB, so ovf can land with diff.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_am  <= 1'b0;
      r_bm  <= 1'b0;
      r_ovf <= 1'b0;
    end else begin
      if (w_load) begin
        r_am <= a[WIDTH-1];
        r_bm <= b[WIDTH-1];
      end
      if (r_state == ST_RUN && r_cnt == LAST) begin
        r_ovf <= (r_am ^ r_bm) & (r_am ^ w_d);
      end
    end
  end

  assign ovf = r_ovf;
`endif

  assign busy       = (r_state == ST_RUN);
  assign done       = (r_state == ST_DONE);
  assign diff       = r_diff;
  assign borrow_out = r_bout;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH=8.
// Overflow checks are built when SERIAL_SUB_OVERFLOW_EN is defined.
module tb_serial_subtractor;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow_out;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic         ovf;
`endif

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out)
`ifdef SERIAL_SUB_OVERFLOW_EN
    ,
    .ovf        (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [W-1:0] ia, input logic [W-1:0] ib);
    exp_t e;
    start = 1'b1;
    a     = ia;
    b     = ib;
    e.d   = ia - ib;
    e.bo  = (ia < ib);
    e.ov  = (ia[W-1] ^ ib[W-1]) & (ia[W-1] ^ e.d[W-1]);
    sb.push_back(e);
  endtask

  // Waits (bounded) for done; lat=-1 on timeout. Drops start after one cycle.
  task automatic wait_done(output int lat, output int nbusy, output bit both);
    lat   = -1;
    nbusy = 0;
    both  = 1'b0;
    for (int n = 1; n <= W + 6; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) nbusy++;
      if (busy && done) both = 1'b1;
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl busy=%b done=%b required 0 0", busy, done);
    end
    checks++;
    if (diff !== 8'h00 || borrow_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_data diff=%h bo=%b required 00 0", diff, borrow_out);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle busy=%b done=%b required 0 0", busy, done);
    end
  endtask

  task automatic test_basic;
    int   lat, nb;
    bit   both;
    exp_t e;
    @(negedge clk);
    drive(8'h05, 8'h03);
    wait_done(lat, nb, both);
    checks++;
    if (lat != W + 1 || nb != W || both) begin
      errors++;
      $display("FAIL basic_timing lat=%0d busy=%0d both=%b required %0d %0d 0",
               lat, nb, both, W + 1, W);
    end
    e = sb.pop_front();
    checks++;
    if (diff !== e.d || borrow_out !== e.bo || diff !== 8'h02) begin
      errors++;
      $display("FAIL basic_result diff=%h bo=%b required %h %b",
               diff, borrow_out, e.d, e.bo);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || diff !== 8'h02) begin
      errors++;
      $display("FAIL basic_pulse done=%b busy=%b diff=%h required 0 0 02",
               done, busy, diff);
    end
  endtask

  task automatic test_borrow;
    logic [W-1:0] ta [3] = '{8'h03, 8'h00, 8'h00};
    logic [W-1:0] tb [3] = '{8'h05, 8'hFF, 8'h00};
    logic [W-1:0] td [3] = '{8'hFE, 8'h01, 8'h00};
    logic         tbo[3] = '{1'b1, 1'b1, 1'b0};
    int   lat, nb;
    bit   both;
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(ta[i], tb[i]);
      wait_done(lat, nb, both);
      e = sb.pop_front();
      checks++;
      if (lat != W + 1 || diff !== td[i] || borrow_out !== tbo[i]
          || diff !== e.d || borrow_out !== e.bo) begin
        errors++;
        $display("FAIL borrow_%0d lat=%0d diff=%h bo=%b required %0d %h %b",
                 i, lat, diff, borrow_out, W + 1, td[i], tbo[i]);
      end
    end
  endtask

  task automatic test_ignored_start;
    int   lat, nb;
    bit   both;
    exp_t e;
    @(negedge clk);
    drive(8'h33, 8'h11);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1;
    a     = 8'hAA;
    b     = 8'h55;
    wait_done(lat, nb, both);
    e = sb.pop_front();
    checks++;
    if (lat != W - 2 || diff !== e.d || borrow_out !== e.bo) begin
      errors++;
      $display("FAIL ignored_start lat=%0d diff=%h bo=%b required %0d %h %b",
               lat, diff, borrow_out, W - 2, e.d, e.bo);
    end
    wait_done(lat, nb, both);
    checks++;
    if (lat != -1 || nb != 0) begin
      errors++;
      $display("FAIL ignored_noqueue lat=%0d busy=%0d required -1 0", lat, nb);
    end
  endtask

  task automatic test_back_to_back;
    int   lat, nb;
    bit   both;
    exp_t e;
    @(negedge clk);
    drive(8'h44, 8'h04);
    wait_done(lat, nb, both);
    e = sb.pop_front();
    checks++;
    if (lat != W + 1 || diff !== 8'h40 || diff !== e.d) begin
      errors++;
      $display("FAIL b2b_first lat=%0d diff=%h required %0d 40", lat, diff, W + 1);
    end
    drive(8'h10, 8'h01);
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || diff !== 8'h40) begin
      errors++;
      $display("FAIL b2b_hold busy=%b diff=%h required 1 40", busy, diff);
    end
    wait_done(lat, nb, both);
    e = sb.pop_front();
    checks++;
    if (lat != W || nb != W - 1 || both || diff !== 8'h0F || diff !== e.d
        || borrow_out !== e.bo) begin
      errors++;
      $display("FAIL b2b_second lat=%0d busy=%0d diff=%h bo=%b required %0d %0d 0f 0",
               lat, nb, diff, borrow_out, W, W - 1);
    end
  endtask

  task automatic test_reset_mid;
    int   lat, nb;
    bit   both;
    exp_t e;
    @(negedge clk);
    drive(8'hF0, 8'h0F);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || diff !== 8'h00 || borrow_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid busy=%b done=%b diff=%h bo=%b required 0 0 00 0",
               busy, done, diff, borrow_out);
    end
    void'(sb.pop_front());
    @(negedge clk);
    rst_n = 1'b1;
    wait_done(lat, nb, both);
    checks++;
    if (lat != -1 || nb != 0) begin
      errors++;
      $display("FAIL reset_nodone lat=%0d busy=%0d required -1 0", lat, nb);
    end
    @(negedge clk);
    drive(8'h05, 8'h03);
    wait_done(lat, nb, both);
    e = sb.pop_front();
    checks++;
    if (lat != W + 1 || diff !== 8'h02 || diff !== e.d || borrow_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_after lat=%0d diff=%h bo=%b required %0d 02 0",
               lat, diff, borrow_out, W + 1);
    end
  endtask

`ifdef SERIAL_SUB_OVERFLOW_EN
  task automatic test_ovf;
    logic [W-1:0] ta [3] = '{8'h80, 8'h7F, 8'h10};
    logic [W-1:0] tb [3] = '{8'h01, 8'hFF, 8'h01};
    logic [W-1:0] td [3] = '{8'h7F, 8'h80, 8'h0F};
    logic         tov[3] = '{1'b1, 1'b1, 1'b0};
    int   lat, nb;
    bit   both;
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(ta[i], tb[i]);
      wait_done(lat, nb, both);
      e = sb.pop_front();
      checks++;
      if (lat != W + 1 || diff !== td[i] || ovf !== tov[i] || ovf !== e.ov) begin
        errors++;
        $display("FAIL ovf_%0d diff=%h ovf=%b required %h %b",
                 i, diff, ovf, td[i], tov[i]);
      end
    end
  endtask
`endif

  task automatic test_sweep;
    logic [W-1:0] corner[5] = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF};
    logic [W-1:0] qa[$];
    logic [W-1:0] qb[$];
    int   lat, nb;
    bit   both;
    bit   bad;
    exp_t e;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++) begin
        qa.push_back(corner[i]);
        qb.push_back(corner[j]);
      end
    for (int i = 0; i < 1000; i++) begin
      qa.push_back(W'($urandom));
      qb.push_back(W'($urandom));
    end
    @(negedge clk);
    drive(qa[0], qb[0]);
    for (int i = 0; i < qa.size(); i++) begin
      wait_done(lat, nb, both);
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sweep_empty op=%0d", i);
        break;
      end
      e = sb.pop_front();
      bad = (lat != W + 1) || both || diff !== e.d || borrow_out !== e.bo;
`ifdef SERIAL_SUB_OVERFLOW_EN
      bad = bad || (ovf !== e.ov);
`endif
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL sweep a=%h b=%h lat=%0d diff=%h bo=%b required %h %b",
                 qa[i], qb[i], lat, diff, borrow_out, e.d, e.bo);
      end
      if (lat < 0) break;
      if (i + 1 < qa.size()) drive(qa[i+1], qb[i+1]);
    end
    start = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_borrow();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid();
`ifdef SERIAL_SUB_OVERFLOW_EN
    test_ovf();
`endif
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
